iob_ext_mem_arbiter: RTL
========================

// Module: iob_ext_mem_arbiter
// PURPOSE
//  Shares one true-2-port byte-enable RAM (iob_ram_t2p_be: 1 read port, 1 write port, 1-cycle read latency)
//  between N_REQ IOb-native requesters, e.g. CPU data bus and a DMA engine, in front of ext_mem_mem.
//  Read port and write port are arbitrated independently, so a read and a write from different
//  requesters complete in the same cycle. Sits between the SoC interconnect and the mwrap memory pins.
// PARAMETERS
//  N_REQ       2   number of requesters (2..8)
//  DATA_W      32  data width; strobe width DATA_W/8
//  MEM_ADDR_W  13  RAM word-address width
//  ADDR_W      15  requester byte-address width = MEM_ADDR_W+2
// PORTS
//  clk_i         in   1               clock, rising edge
//  arst_n_i      in   1               asynchronous reset, active low
//  cke_i         in   1               clock enable; all state holds when 0
//  req_valid_i   in   N_REQ           per-requester request valid
//  req_addr_i    in   N_REQ*ADDR_W    byte address, requester k at [k*ADDR_W +: ADDR_W]
//  req_wdata_i   in   N_REQ*DATA_W    write data
//  req_wstrb_i   in   N_REQ*DATA_W/8  byte strobes; nonzero = write, zero = read
//  req_ready_o   out  N_REQ           request accepted this cycle (combinational)
//  req_rvalid_o  out  N_REQ           read data valid
//  req_rdata_o   out  N_REQ*DATA_W    read data
//  mem_r_en_o    out  1               RAM read enable
//  mem_r_addr_o  out  MEM_ADDR_W      RAM read word address
//  mem_r_data_i  in   DATA_W          RAM read data (valid 1 cycle after mem_r_en_o)
//  mem_w_strb_o  out  DATA_W/8        RAM write strobes (0 = no write)
//  mem_w_addr_o  out  MEM_ADDR_W      RAM write word address
//  mem_w_data_o  out  DATA_W          RAM write data
// BEHAVIOUR
//  - Reset: req_rvalid_o=0, req_rdata_o=0, both RR pointers=requester 0, read-tag register cleared.
//    Mem outputs are combinational from grants, so they are 0 while no request is valid.
//  - Classify: write_req[k]=valid&|wstrb, read_req[k]=valid&~|wstrb. Word addr = addr[ADDR_W-1:2].
//  - Write arbiter: round-robin over write_req; grant gw drives mem_w_*; req_ready_o[gw]=1 same cycle.
//  - Read arbiter: round-robin over read_req; grant gr drives mem_r_en_o=1, mem_r_addr_o; ready[gr]=1.
//  - Round-robin: highest priority = requester after last accepted one; pointer advances only
//    on accept (grant & cke_i). Requester holds valid/addr/data until ready (IOb rule).
//  - Collision: if the granted read and granted write target the same word in the same cycle,
//    the read is not issued (mem_r_en_o=0, ready withheld, read pointer unchanged); it issues
//    next cycle and returns post-write data. Write is never stalled by a read.
//  - Read response: register tag=gr on accepted read; next cycle req_rvalid_o[tag]=1 for exactly one
//    cycle, req_rdata_o slice[tag]=mem_r_data_i; other slices unchanged. Back-to-back reads,
//    one per cycle, full throughput. Latency: accept at T -> rvalid at T+1.
//  - A requester has at most one request per cycle; no write response (ready = done).
//  - cke_i=0: no grant accepted (ready all 0, mem_r_en_o=0, mem_w_strb_o=0), pending rvalid held.
//  - Reset asserted mid-read: pending rvalid dropped, pointers return to 0; no spurious rvalid after release.
//  - Single requester continuously valid: granted every cycle (no bubble).
// STRUCTURE
//  - iob_ext_mem_arbiter_conf.vh: default N_REQ/DATA_W/MEM_ADDR_W macros, used as parameter defaults.
//  - Sub-module iob_rr_arbiter #(N): inputs req[N], accept; outputs one-hot grant, binary grant index;
//    internal last-grant pointer on clk_i/arst_n_i/cke_i. Instantiated twice (read, write).
//  - Top: request classification, mux of granted addr/data, collision compare, read-tag register,
//    rdata demux.
// TESTING
//  1 Reset: arst_n_i=0 with valid traffic -> all rvalid 0, mem_r_en_o=0, mem_w_strb_o=0.
//  2 Req0 writes 0xDEADBEEF, wstrb 0xF, addr 0x40; next cycle req1 reads 0x40 -> ready1 same
//    cycle, rvalid1 one cycle later, rdata1=0xDEADBEEF.
//  3 Both requesters read continuously, addrs 0x0/0x4 -> grants alternate 0,1,0,1; each rvalid
//    returns the data of its own address; no cycle without mem_r_en_o.
//  4 Same cycle req0 write 0x11223344 @0x80, req1 read @0x80 -> write issues, read stalls 1
//    cycle, rdata1=0x11223344; req0 write 0x5 @0x84 with req1 read @0x80 -> both ready same cycle.
//  5 Partial write wstrb=0x2, wdata=0x0000AB00 onto 0xFFFFFFFF -> readback 0xFFFFABFF.
//  6 cke_i=0 for 3 cycles mid-stream, then reset during an outstanding read -> no grants while
//    low, pending rvalid held then dropped by reset, RR order restarts at requester 0.

Source files
------------

// File: rtl/iob_ext_mem_arbiter_pkg.sv
// iob_ext_mem_arbiter_pkg: default geometry and index-width helper for the external memory arbiter
package iob_ext_mem_arbiter_pkg;
    localparam int N_REQ_DEF      = 2;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_ADDR_W_DEF = 13;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin arbiter; priority starts at the requester after the last accepted one
module iob_rr_arbiter
    import iob_ext_mem_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic          cke_i,
    input  logic [N-1:0]  req_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;

    // scan from lowest priority up so the highest-priority requester wins last
    always_comb begin
        int k;
        k = 0;
        grant_o = '0;
        grant_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr_q) + i) % N;
            if (|(req_i & (N'(1) << k))) begin
                grant_o = N'(1) << k;
                grant_idx_o = IW'(k);
            end
        end
    end

    assign ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) ptr_q <= '0;
        else if (cke_i && accept_i && |req_i) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/iob_ext_mem_arbiter.sv
// iob_ext_mem_arbiter: shares a 1R/1W byte-enable RAM between N_REQ IOb requesters with independent RR arbiters
module iob_ext_mem_arbiter
    import iob_ext_mem_arbiter_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int ADDR_W     = MEM_ADDR_W + 2
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           req_rvalid_o,
    output logic [N_REQ*DATA_W-1:0]    req_rdata_o,
    output logic                       mem_r_en_o,
    output logic [MEM_ADDR_W-1:0]      mem_r_addr_o,
    input  logic [DATA_W-1:0]          mem_r_data_i,
    output logic [DATA_W/8-1:0]        mem_w_strb_o,
    output logic [MEM_ADDR_W-1:0]      mem_w_addr_o,
    output logic [DATA_W-1:0]          mem_w_data_o
);
    localparam int SW = DATA_W / 8;
    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]        wr_req, rd_req, wr_gnt, rd_gnt;
    logic [IW-1:0]           gw, gr, tag_q;
    logic                    pend_q, en, w_any, r_any, coll, r_go;
    logic [MEM_ADDR_W-1:0]   w_word, r_word;
    logic [N_REQ*DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]              unused_addr_lsb;

    always_comb begin
        wr_req = '0;
        rd_req = '0;
        unused_addr_lsb = '0;
        for (int k = 0; k < N_REQ; k++) begin
            wr_req[k] = req_valid_i[k] & (|req_wstrb_i[k*SW +: SW]);
            rd_req[k] = req_valid_i[k] & ~(|req_wstrb_i[k*SW +: SW]);
            unused_addr_lsb ^= req_addr_i[k*ADDR_W +: 2];
        end
    end

    iob_rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .req_i(wr_req), .accept_i(en), .grant_o(wr_gnt), .grant_idx_o(gw)
    );

    iob_rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .req_i(rd_req), .accept_i(r_go), .grant_o(rd_gnt), .grant_idx_o(gr)
    );

    assign en     = cke_i & arst_n_i;
    assign w_any  = |wr_req;
    assign r_any  = |rd_req;
    assign w_word = req_addr_i[int'(gw)*ADDR_W + 2 +: MEM_ADDR_W];
    assign r_word = req_addr_i[int'(gr)*ADDR_W + 2 +: MEM_ADDR_W];
    // a read hitting the word being written waits one cycle so it returns post-write data
    assign coll   = w_any & r_any & (w_word == r_word);
    assign r_go   = en & r_any & ~coll;

    assign mem_w_strb_o = (en & w_any) ? req_wstrb_i[int'(gw)*SW +: SW] : '0;
    assign mem_w_addr_o = w_any ? w_word : '0;
    assign mem_w_data_o = w_any ? req_wdata_i[int'(gw)*DATA_W +: DATA_W] : '0;
    assign mem_r_en_o   = r_go;
    assign mem_r_addr_o = r_any ? r_word : '0;
    assign req_ready_o  = (wr_gnt & {N_REQ{en}}) | (rd_gnt & {N_REQ{r_go}});

    assign req_rvalid_o = pend_q ? (N_REQ'(1) << tag_q) : '0;
    assign req_rdata_o  = rdata_d;

    // the responding slice passes RAM data straight through; the rest keep their last value
    always_comb begin
        rdata_d = rdata_q;
        if (pend_q) rdata_d[int'(tag_q)*DATA_W +: DATA_W] = mem_r_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pend_q  <= 1'b0;
            tag_q   <= '0;
            rdata_q <= '0;
        end else if (cke_i) begin
            pend_q  <= r_go;
            rdata_q <= rdata_d;
            if (r_go) tag_q <= gr;
        end
    end
endmodule
